// File: rtl/mcu_block_sequencer.sv
// Level-shifts and clamps IDCT blocks arriving in 4:2:0 MCU order, tags each block with
// its channel and Y index, and flags MCU, frame and aborted-MCU boundaries (1-cycle latency).
module mcu_block_sequencer #(
  parameter int IN_W  = 12,
  parameter int MCU_W = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             frame_start,
  input  logic [MCU_W-1:0]                 num_mcus_in,
  input  logic                             valid_in,
  input  logic signed [7:0][7:0][IN_W-1:0] block_in,
  output logic                             valid_out,
  output logic [1:0]                       ch_out,
  output logic [1:0]                       y_idx_out,
  output logic [7:0][7:0][8:0]             block_out,
  output logic                             mcu_done,
  output logic                             frame_done,
  output logic                             abort
);

  logic [2:0]       blk_cnt;
  logic [MCU_W-1:0] mcu_cnt;
  logic [MCU_W-1:0] num_mcus_reg;

  logic [2:0]       cur_blk;
  logic [MCU_W-1:0] cur_mcu;
  logic [MCU_W-1:0] cur_num;
  logic [MCU_W-1:0] start_num;
  logic [7:0][7:0][8:0] shifted;

  // x + 128 never leaves the IN_W+1 bit signed range, so the sign bit and the
  // bits above bit 7 are enough to decide the clamp.
  function automatic logic [8:0] level_shift(input logic [IN_W-1:0] x);
    logic [IN_W:0] sum;
    sum = {x[IN_W-1], x} + (IN_W+1)'(128);
    if (sum[IN_W])
      return 9'd0;
    else if (|sum[IN_W-1:8])
      return 9'd255;
    else
      return {1'b0, sum[7:0]};
  endfunction

  always_comb begin
    shifted = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        shifted[i][j] = level_shift(block_in[i][j]);
  end

  // frame_start clears the position before a concurrent block is tagged.
  always_comb begin
    start_num = (num_mcus_in == '0) ? MCU_W'(1) : num_mcus_in;
    cur_blk   = frame_start ? 3'd0 : blk_cnt;
    cur_mcu   = frame_start ? '0 : mcu_cnt;
    cur_num   = frame_start ? start_num : num_mcus_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out    <= 1'b0;
      ch_out       <= 2'd0;
      y_idx_out    <= 2'd0;
      block_out    <= '0;
      mcu_done     <= 1'b0;
      frame_done   <= 1'b0;
      abort        <= 1'b0;
      blk_cnt      <= 3'd0;
      mcu_cnt      <= '0;
      num_mcus_reg <= MCU_W'(1);
    end else begin
      valid_out    <= 1'b0;
      mcu_done     <= 1'b0;
      frame_done   <= 1'b0;
      abort        <= frame_start && (blk_cnt != 3'd0);
      num_mcus_reg <= cur_num;
      blk_cnt      <= cur_blk;
      mcu_cnt      <= cur_mcu;
      if (valid_in) begin
        valid_out <= 1'b1;
        block_out <= shifted;
        case (cur_blk)
          3'd4:    begin ch_out <= 2'd1; y_idx_out <= 2'd0; end
          3'd5:    begin ch_out <= 2'd2; y_idx_out <= 2'd0; end
          default: begin ch_out <= 2'd0; y_idx_out <= cur_blk[1:0]; end
        endcase
        if (cur_blk == 3'd5) begin
          blk_cnt  <= 3'd0;
          mcu_done <= 1'b1;
          if (cur_mcu == cur_num - MCU_W'(1)) begin
            frame_done <= 1'b1;
            mcu_cnt    <= '0;
          end else begin
            mcu_cnt <= cur_mcu + MCU_W'(1);
          end
        end else begin
          blk_cnt <= cur_blk + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mcu_block_sequencer.sv
// Scoreboard bench for mcu_block_sequencer: expectations are queued as blocks are driven
// and compared by a negedge monitor when the block emerges.
module tb_mcu_block_sequencer;

  typedef logic [7:0][7:0][11:0] iblk_t;
  typedef logic [7:0][7:0][8:0]  oblk_t;
  typedef struct {
    logic [1:0] ch;
    logic [1:0] y;
    logic       md;
    logic       fd;
    oblk_t      blk;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        frame_start;
  logic [15:0] num_mcus_in;
  logic        valid_in;
  iblk_t       block_in;
  logic        valid_out;
  logic [1:0]  ch_out;
  logic [1:0]  y_idx_out;
  oblk_t       block_out;
  logic        mcu_done;
  logic        frame_done;
  logic        abort;

  int   checks = 0;
  int   errors = 0;
  int   out_n = 0;
  int   abort_seen = 0;
  exp_t sb[$];

  mcu_block_sequencer #(.IN_W(12), .MCU_W(16)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .num_mcus_in(num_mcus_in),
    .valid_in(valid_in), .block_in(block_in), .valid_out(valid_out), .ch_out(ch_out),
    .y_idx_out(y_idx_out), .block_out(block_out), .mcu_done(mcu_done),
    .frame_done(frame_done), .abort(abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic oblk_t ref_blk(input iblk_t b);
    oblk_t r;
    int v;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        v = $signed(b[i][j]);
        v = v + 128;
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        r[i][j] = 9'(v);
      end
    return r;
  endfunction

  function automatic iblk_t rand_blk();
    iblk_t b;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        b[i][j] = 12'($urandom_range(0, 4095));
    return b;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (abort === 1'b1) abort_seen++;
    if (valid_out === 1'b1) begin
      out_n++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output #%0d: valid_out 1, required no output", out_n);
      end else begin
        e = sb.pop_front();
        if (ch_out !== e.ch || y_idx_out !== e.y || mcu_done !== e.md ||
            frame_done !== e.fd || block_out !== e.blk) begin
          errors++;
          $display("FAIL output_%0d: ch %0d/%0d y %0d/%0d mcu_done %b/%b frame_done %b/%b blk %h / %h",
                   out_n, ch_out, e.ch, y_idx_out, e.y, mcu_done, e.md, frame_done, e.fd,
                   block_out, e.blk);
        end
      end
    end else if (rst === 1'b0 && (mcu_done !== 1'b0 || frame_done !== 1'b0)) begin
      checks++;
      errors++;
      $display("FAIL stray_done: mcu_done %b frame_done %b without valid_out, required 0 0",
               mcu_done, frame_done);
    end
  end

  task automatic send(input iblk_t b, input logic fs, input logic [15:0] num,
                      input logic [1:0] ch, input logic [1:0] y, input logic md,
                      input logic fd, input oblk_t eb);
    exp_t e;
    @(negedge clk);
    frame_start = fs;
    num_mcus_in = num;
    valid_in    = 1'b1;
    block_in    = b;
    e.ch = ch; e.y = y; e.md = md; e.fd = fd; e.blk = eb;
    sb.push_back(e);
  endtask

  // Sends a block at MCU position pos (0..5) with a randomised or supplied payload.
  task automatic send_pos(input iblk_t b, input int pos, input logic fd);
    logic [1:0] ch;
    logic [1:0] y;
    ch = (pos < 4) ? 2'd0 : 2'(pos - 3);
    y  = (pos < 4) ? 2'(pos) : 2'd0;
    send(b, 1'b0, 16'd0, ch, y, pos == 5, fd, ref_blk(b));
  endtask

  task automatic idle(input logic fs, input logic [15:0] num);
    @(negedge clk);
    frame_start = fs;
    num_mcus_in = num;
    valid_in    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (valid_out !== 1'b0 || ch_out !== 2'd0 || y_idx_out !== 2'd0 || block_out !== '0 ||
        mcu_done !== 1'b0 || frame_done !== 1'b0 || abort !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: v %b ch %0d y %0d md %b fd %b ab %b blk_nonzero %b, required all 0",
               valid_out, ch_out, y_idx_out, mcu_done, frame_done, abort, block_out != '0);
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    iblk_t z;
    int a0;
    z  = '0;
    a0 = abort_seen;
    idle(1'b1, 16'd2);
    for (int k = 0; k < 12; k++) begin
      send_pos(z, k % 6, k == 11);
      sb[sb.size()-1].blk = {64{9'd128}};
    end
    idle(1'b0, 16'd0);
    idle(1'b0, 16'd0);
    checks++;
    if (abort_seen != a0) begin
      errors++;
      $display("FAIL b2b_no_abort: %0d abort pulses, required 0", abort_seen - a0);
    end
  endtask

  task automatic test_clamp_ramp();
    iblk_t b;
    iblk_t r;
    oblk_t eb;
    int    vals[7] = '{-300, -128, -1, 0, 127, 128, 2047};
    int    exps[7] = '{0, 0, 127, 128, 255, 255, 255};
    b  = rand_blk();
    for (int j = 0; j < 7; j++) b[0][j] = 12'(vals[j]);
    eb = ref_blk(b);
    for (int j = 0; j < 7; j++) eb[0][j] = 9'(exps[j]);
    send(b, 1'b1, 16'd0, 2'd0, 2'd0, 1'b0, 1'b0, eb);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        r[i][j]  = 12'(8 * i + j - 128);
        eb[i][j] = 9'(8 * i + j);
      end
    send(r, 1'b0, 16'd0, 2'd0, 2'd1, 1'b0, 1'b0, eb);
    for (int p = 2; p < 6; p++) send_pos(rand_blk(), p, p == 5);
    idle(1'b0, 16'd0);
  endtask

  task automatic test_abort();
    int    a0;
    iblk_t b;
    a0 = abort_seen;
    for (int p = 0; p < 3; p++) send_pos(rand_blk(), p, 1'b0);
    b = rand_blk();
    send(b, 1'b1, 16'd3, 2'd0, 2'd0, 1'b0, 1'b0, ref_blk(b));
    for (int p = 1; p < 6; p++) send_pos(rand_blk(), p, 1'b0);
    idle(1'b0, 16'd0);
    idle(1'b0, 16'd0);
    checks++;
    if (abort_seen - a0 != 1) begin
      errors++;
      $display("FAIL abort_count: %0d abort pulses, required 1", abort_seen - a0);
    end
  endtask

  task automatic test_gaps();
    idle(1'b1, 16'd2);
    for (int k = 0; k < 12; k++) begin
      send_pos(rand_blk(), k % 6, k == 11);
      idle(1'b0, 16'd0);
      @(posedge clk);
      #1;
      checks++;
      if (valid_out !== 1'b0) begin
        errors++;
        $display("FAIL gap_%0d: valid_out %b, required 0", k, valid_out);
      end
    end
  endtask

  task automatic test_reset_mid_mcu();
    int a0;
    a0 = abort_seen;
    for (int p = 0; p < 4; p++) send_pos(rand_blk(), p, 1'b0);
    @(negedge clk);
    rst         = 1'b1;
    valid_in    = 1'b1;
    block_in    = rand_blk();
    @(negedge clk);
    rst      = 1'b0;
    valid_in = 1'b0;
    checks++;
    if (valid_out !== 1'b0 || ch_out !== 2'd0 || y_idx_out !== 2'd0 || block_out !== '0 ||
        mcu_done !== 1'b0 || frame_done !== 1'b0 || abort !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_mcu: v %b ch %0d y %0d md %b fd %b ab %b blk_nonzero %b, required all 0",
               valid_out, ch_out, y_idx_out, mcu_done, frame_done, abort, block_out != '0);
    end
    // num_mcus_reg is back to 1, so this single MCU is a whole frame.
    for (int p = 0; p < 6; p++) send_pos(rand_blk(), p, p == 5);
    idle(1'b0, 16'd0);
    idle(1'b0, 16'd0);
    checks++;
    if (abort_seen != a0) begin
      errors++;
      $display("FAIL reset_no_abort: %0d abort pulses, required 0", abort_seen - a0);
    end
  endtask

  initial begin
    rst         = 1'b1;
    frame_start = 1'b0;
    num_mcus_in = 16'd0;
    valid_in    = 1'b0;
    block_in    = '0;
    test_reset();
    test_back_to_back();
    test_clamp_ramp();
    test_abort();
    test_gaps();
    test_reset_mid_mcu();
    repeat (3) idle(1'b0, 16'd0);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_outputs: %0d expected blocks never emerged, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcu_block_sequencer.md
# mcu_block_sequencer

Upstream feeder for the chroma supersample buffer. It accepts a stream of decoded 8x8 blocks from the IDCT stage in 4:2:0 MCU order (Y0, Y1, Y2, Y3, Cb, Cr). For each block it applies the +128 level shift, clamps to 0..255 and tags the block with its channel. It presents the result on the valid/ch/block interface consumed by the supersample buffer, and tracks MCU and frame boundaries.

## Interface
- IN_W, 12, signed IDCT sample width
- MCU_W, 16, width of MCU counter / MCU count input
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse; begins a new frame, latches num_mcus_in
- num_mcus_in  in  MCU_W  MCUs in the frame (valid with frame_start; 0 treated as 1)
- valid_in  in  1  block_in carries one IDCT block this cycle
- block_in  in  signed [IN_W-1:0] [7:0][7:0]  IDCT output block
- valid_out  out  1  block_out/ch_out valid this cycle
- ch_out  out  $clog2(`CH+1) (2 for CH=3)  0=Y, 1=Cb, 2=Cr
- y_idx_out  out  2  Y block index 0..3 within MCU; 0 for chroma
- block_out  out  [8:0] [7:0][7:0]  level-shifted, clamped sample, zero-extended to 9 bits
- mcu_done  out  1  pulse with the Cr block of every MCU
- frame_done  out  1  pulse with the Cr block of the last MCU of the frame
- abort  out  1  pulse; frame_start arrived while an MCU was partially received

## Operation
- blk_cnt (0..5) gives the position within the current MCU. Channel mapping: 0–3 → ch 0 with y_idx = blk_cnt; 4 → ch 1; 5 → ch 2.
- Each valid_in block is registered into the output stage and advances blk_cnt. At 5 blk_cnt wraps to 0 and mcu_cnt increments.
- Per sample: s = block_in[i][j] + 128, computed at IN_W+1 bits signed. Clamp: s < 0 → 0; s > 255 → 255; otherwise s. block_out[i][j] = {1'b0, s[7:0]}. Index order is preserved ([i][j] out = [i][j] in).
- frame_start:
  - clears blk_cnt and mcu_cnt and latches num_mcus_reg = max(num_mcus_in, 1).
  - If blk_cnt != 0 at that moment, abort pulses next cycle. The partial MCU is discarded from the count only; already-emitted blocks are not recalled.
  - frame_start together with valid_in: the clear applies first, so that block is Y0 of the new frame.
- Last MCU: when the Cr block is emitted with mcu_cnt == num_mcus_reg-1, frame_done pulses together with mcu_done, and mcu_cnt wraps to 0. Further blocks without frame_start start another frame with the same num_mcus_reg.
- No backpressure exists: the downstream buffer accepts every valid_out, so one block per cycle is sustained indefinitely.
- Gaps (valid_in low) hold all counters and output nothing.

## Timing
- Latency is 1 cycle: valid_in at edge N gives valid_out, ch_out, y_idx_out, block_out, mcu_done and frame_done high during cycle N+1.
- valid_out, mcu_done, frame_done and abort are single-cycle pulses unless the next cycle also carries a block.
- block_out and ch_out hold their last value when valid_out is low. The value is don't-care for consumers but must be stable (no X).
- Reset values: valid_out 0, ch_out 0, y_idx_out 0, block_out all 0, mcu_done 0, frame_done 0, abort 0, blk_cnt 0, mcu_cnt 0, num_mcus_reg 1.
- rst takes priority over frame_start and valid_in. A block presented in the same cycle as rst is dropped.
- Reset mid-MCU returns the block to the reset state with no abort pulse.

## Test plan
- Feed 12 back-to-back blocks with all samples = 0 after frame_start with num_mcus_in = 2.
  - ch_out sequence 0,0,0,0,1,2,0,0,0,0,1,2.
  - y_idx_out 0,1,2,3,0,0 repeating.
  - Every block_out sample is 128.
  - mcu_done on outputs 6 and 12; frame_done only on output 12.
- Clamp check: one block holding -300, -128, -1, 0, 127, 128, 2047 gives outputs 0, 0, 127, 128, 255, 255, 255. Every other position checked against (x+128) clamped.
- Ramp block with block_in[i][j] = 8*i+j-128 gives block_out[i][j] = 8*i+j exactly. This confirms the index mapping and the 1-cycle latency.
- Deliver 3 blocks, then frame_start with valid_in in the same cycle.
  - abort pulses once.
  - The concurrent block emerges as ch 0, y_idx 0.
  - The following 5 blocks complete the MCU with mcu_done on the Cr block.
- Insert gaps by toggling valid_in across one MCU: counters hold, the output sequence is identical to the back-to-back case, and valid_out is low during gaps.
- Assert rst for 1 cycle while blk_cnt = 4: all outputs are at reset values the next cycle, no abort, and the next block is Y0.
